// File: rtl/periodometro_pkg.sv
// Shared definitions for the period-meter measurement path: sequencer states,
// default widths and the counter saturation value.
package periodometro_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ARMADO     = 2'd1,
        MIDIENDO   = 2'd2,
        PUBLICANDO = 2'd3
    } estado_t;

    localparam int CANT_BITS_DEF     = 12;
    localparam int LOG_PROMEDIOS_DEF = 2;

    // Largest value a per-period tick counter of the given width can hold.
    function automatic logic [31:0] maximo_contador(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/acumulador_promedio.sv
// Running sum of per-period tick samples, a sample counter, and the
// shift-divide average of the window.
module acumulador_promedio
    import periodometro_pkg::*;
#(
    parameter int CANT_BITS     = CANT_BITS_DEF,
    parameter int LOG_PROMEDIOS = LOG_PROMEDIOS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 limpiar_i,
    input  logic                 sumar_i,
    input  logic [CANT_BITS-1:0] muestra_i,
    output logic                 ultimo_o,
    output logic [CANT_BITS-1:0] promedio_o
);

    localparam int AW = CANT_BITS + LOG_PROMEDIOS;
    localparam int NW = (LOG_PROMEDIOS > 0) ? LOG_PROMEDIOS : 1;
    localparam logic [NW-1:0] N_ULTIMO = NW'((2 ** LOG_PROMEDIOS) - 1);

    logic [AW-1:0] acumulador_q, acumulador_d;
    logic [AW-1:0] suma;
    logic [NW-1:0] n_q, n_d;

    // The average already includes the sample being added, so the closing
    // edge of a window can publish without an extra cycle.
    assign suma       = acumulador_q + AW'(muestra_i);
    assign ultimo_o   = (n_q == N_ULTIMO);
    assign promedio_o = CANT_BITS'(suma >> LOG_PROMEDIOS);

    always_comb begin
        acumulador_d = acumulador_q;
        n_d          = n_q;
        if (limpiar_i) begin
            acumulador_d = '0;
            n_d          = '0;
        end else if (sumar_i) begin
            acumulador_d = suma;
            n_d          = n_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acumulador_q <= '0;
            n_q          <= '0;
        end else begin
            acumulador_q <= acumulador_d;
            n_q          <= n_d;
        end
    end

endmodule

// File: rtl/controlador_periodo.sv
// Measurement sequencer: arms on request or in continuous mode, counts
// timebase ticks over a window of periods and publishes the averaged result.
module controlador_periodo
    import periodometro_pkg::*;
#(
    parameter int CANT_BITS     = CANT_BITS_DEF,
    parameter int LOG_PROMEDIOS = LOG_PROMEDIOS_DEF
) (
    input  logic                 reloj_FPGA,
    input  logic                 reset,
    input  logic                 flanco_pos_onda_cuad,
    input  logic                 tick_base,
    input  logic                 iniciar,
    input  logic                 continuo,
    output logic [CANT_BITS-1:0] valor_periodo,
    output logic                 dato_valido,
    output logic                 desborde,
    output logic                 ocupado
);

    localparam logic [CANT_BITS-1:0] SATURADO = CANT_BITS'(maximo_contador(CANT_BITS));

    estado_t              estado_q, estado_d;
    logic [CANT_BITS-1:0] contador_q, contador_d;
    logic                 ovf_q, ovf_d;
    logic [CANT_BITS-1:0] valor_q, valor_d;
    logic                 valido_q, valido_d;
    logic                 desborde_q, desborde_d;
    logic                 ocupado_q, ocupado_d;

    logic                 limpiar;
    logic                 sumar;
    logic [CANT_BITS-1:0] muestra;
    logic                 ultimo;
    logic [CANT_BITS-1:0] promedio;

    acumulador_promedio #(
        .CANT_BITS     (CANT_BITS),
        .LOG_PROMEDIOS (LOG_PROMEDIOS)
    ) u_acumulador (
        .clk_i      (reloj_FPGA),
        .rst_ni     (reset),
        .limpiar_i  (limpiar),
        .sumar_i    (sumar),
        .muestra_i  (muestra),
        .ultimo_o   (ultimo),
        .promedio_o (promedio)
    );

    // A tick coinciding with the closing edge belongs to the closing period;
    // the saturated case is caught first, so this sum never wraps.
    assign muestra = contador_q + CANT_BITS'(tick_base);

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        ovf_d      = ovf_q;
        valor_d    = valor_q;
        desborde_d = desborde_q;
        valido_d   = 1'b0;
        limpiar    = 1'b0;
        sumar      = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (iniciar || continuo) begin
                    estado_d = ARMADO;
                end
            end
            ARMADO: begin
                if (flanco_pos_onda_cuad) begin
                    contador_d = '0;
                    ovf_d      = 1'b0;
                    limpiar    = 1'b1;
                    estado_d   = MIDIENDO;
                end
            end
            MIDIENDO: begin
                if (tick_base && (contador_q == SATURADO)) begin
                    ovf_d      = 1'b1;
                    valido_d   = 1'b1;
                    valor_d    = SATURADO;
                    desborde_d = 1'b1;
                    estado_d   = PUBLICANDO;
                end else if (flanco_pos_onda_cuad) begin
                    sumar      = 1'b1;
                    contador_d = '0;
                    if (ultimo) begin
                        valido_d   = 1'b1;
                        valor_d    = promedio;
                        desborde_d = 1'b0;
                        estado_d   = PUBLICANDO;
                    end
                end else if (tick_base) begin
                    contador_d = contador_q + 1'b1;
                end
            end
            PUBLICANDO: begin
                // The next window's first period started at the closing edge.
                limpiar = 1'b1;
                if (tick_base) begin
                    contador_d = contador_q + 1'b1;
                end
                if (continuo && !ovf_q) begin
                    estado_d = MIDIENDO;
                end else if (continuo) begin
                    estado_d = ARMADO;
                end else begin
                    estado_d = REPOSO;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        ocupado_d = (estado_d != REPOSO);
    end

    always_ff @(posedge reloj_FPGA or negedge reset) begin
        if (!reset) begin
            estado_q   <= REPOSO;
            contador_q <= '0;
            ovf_q      <= 1'b0;
            valor_q    <= '0;
            valido_q   <= 1'b0;
            desborde_q <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            ovf_q      <= ovf_d;
            valor_q    <= valor_d;
            valido_q   <= valido_d;
            desborde_q <= desborde_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign valor_periodo = valor_q;
    assign dato_valido   = valido_q;
    assign desborde      = desborde_q;
    assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_controlador_periodo.sv
// Randomized bench for controlador_periodo: expected results come from
// counting generated ticks per period and averaging them arithmetically.
module tb_controlador_periodo;

    localparam int CB = 12;
    localparam int LP = 2;
    localparam int NPROM = 1 << LP;
    localparam int MAXCNT = (1 << CB) - 1;

    logic          reloj_FPGA = 1'b0;
    logic          reset = 1'b1;
    logic          flanco_pos_onda_cuad = 1'b0;
    logic          tick_base = 1'b0;
    logic          iniciar = 1'b0;
    logic          continuo = 1'b0;
    logic [CB-1:0] valor_periodo;
    logic          dato_valido;
    logic          desborde;
    logic          ocupado;

    int errores = 0;
    int checks = 0;
    int pulsos = 0;
    int expPulsos = 0;
    int largos[4];

    controlador_periodo #(
        .CANT_BITS     (CB),
        .LOG_PROMEDIOS (LP)
    ) dut (
        .reloj_FPGA           (reloj_FPGA),
        .reset                (reset),
        .flanco_pos_onda_cuad (flanco_pos_onda_cuad),
        .tick_base            (tick_base),
        .iniciar              (iniciar),
        .continuo             (continuo),
        .valor_periodo        (valor_periodo),
        .dato_valido          (dato_valido),
        .desborde             (desborde),
        .ocupado              (ocupado)
    );

    always #5 reloj_FPGA = ~reloj_FPGA;

    // Counts every published result, independently of the scenario checks.
    always @(negedge reloj_FPGA) begin
        if (dato_valido) pulsos <= pulsos + 1;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errores++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of inputs; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic e, input logic t);
        flanco_pos_onda_cuad = e;
        tick_base = t;
        @(posedge reloj_FPGA);
        #1;
        flanco_pos_onda_cuad = 1'b0;
        tick_base = 1'b0;
    endtask

    function automatic logic tickBit(input int modo);
        if (modo == 0) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // One period of 'largo' clocks closed by an edge; reports ticks inside it.
    task automatic periodo(input int largo, input int modo, output int ticks);
        ticks = 0;
        for (int i = 1; i <= largo; i++) begin
            logic t;
            t = tickBit(modo);
            ticks += int'(t);
            applyStimulus(i == largo, t);
        end
    endtask

    task automatic armar(input string tag, input logic porContinuo);
        if (porContinuo) continuo = 1'b1;
        else iniciar = 1'b1;
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        iniciar = 1'b0;
        checkOutput({tag, ".ocupado_arm"}, int'(ocupado), 1);
        applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    endtask

    // Four periods from largos[]; expected average = sum of ticks / 2^LP.
    task automatic runWindow(input string tag, input int modo, input int cortarEn);
        int suma;
        int t;
        suma = 0;
        for (int k = 0; k < NPROM; k++) begin
            if (k == cortarEn) continuo = 1'b0;
            periodo(largos[k], modo, t);
            suma += t;
            if (k < NPROM - 1) checkOutput({tag, ".quieto"}, int'(dato_valido), 0);
        end
        expPulsos++;
        checkOutput({tag, ".valido"}, int'(dato_valido), 1);
        checkOutput({tag, ".valor"}, int'(valor_periodo), suma / NPROM);
        checkOutput({tag, ".desborde"}, int'(desborde), 0);
        checkOutput({tag, ".ocupado"}, int'(ocupado), 1);
    endtask

    task automatic finTiro(input string tag, input int valorEsperado);
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        iniciar = 1'b0;
        checkOutput({tag, ".ocupado_fin"}, int'(ocupado), 0);
        checkOutput({tag, ".valido_fin"}, int'(dato_valido), 0);
        checkOutput({tag, ".valor_hold"}, int'(valor_periodo), valorEsperado);
        checkOutput({tag, ".pulsos"}, pulsos, expPulsos);
    endtask

    task automatic overflow(input string tag);
        for (int i = 0; i < MAXCNT; i++) applyStimulus(1'b0, 1'b1);
        checkOutput({tag, ".antes"}, int'(dato_valido), 0);
        applyStimulus(1'b0, 1'b1);
        expPulsos++;
        checkOutput({tag, ".valido"}, int'(dato_valido), 1);
        checkOutput({tag, ".valor"}, int'(valor_periodo), MAXCNT);
        checkOutput({tag, ".desborde"}, int'(desborde), 1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        checkOutput("reset0.valor", int'(valor_periodo), 0);
        checkOutput("reset0.valido", int'(dato_valido), 0);
        checkOutput("reset0.desborde", int'(desborde), 0);
        checkOutput("reset0.ocupado", int'(ocupado), 0);
        repeat (2) @(posedge reloj_FPGA);
        #3 reset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle.ocupado", int'(ocupado), 0);

        $display("[TB] single shot, period 100");
        armar("uno", 1'b0);
        largos = '{100, 100, 100, 100};
        runWindow("uno", 0, -1);
        finTiro("uno", 100);

        $display("[TB] truncation with iniciar held while busy");
        iniciar = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("trunc.ocupado_arm", int'(ocupado), 1);
        applyStimulus(1'b1, 1'b1);
        largos = '{10, 11, 11, 11};
        runWindow("trunc", 0, -1);
        finTiro("trunc", 10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("trunc.sigue_reposo", int'(ocupado), 0);

        $display("[TB] random single shots");
        for (int w = 0; w < 2; w++) begin
            int esperado;
            armar("rnd", 1'b0);
            for (int k = 0; k < NPROM; k++) largos[k] = $urandom_range(2, 300);
            runWindow("rnd", 1, -1);
            esperado = int'(valor_periodo);
            finTiro("rnd", esperado);
        end

        $display("[TB] overflow single shot");
        armar("ovf", 1'b0);
        overflow("ovf");
        finTiro("ovf", MAXCNT);
        checkOutput("ovf.desborde_hold", int'(desborde), 1);

        $display("[TB] maximum period without overflow");
        armar("max", 1'b0);
        largos = '{MAXCNT, MAXCNT, MAXCNT, MAXCNT};
        runWindow("max", 0, -1);
        finTiro("max", MAXCNT);

        $display("[TB] continuous, period 50 then random");
        armar("cont", 1'b1);
        largos = '{50, 50, 50, 50};
        runWindow("cont50a", 0, -1);
        runWindow("cont50b", 0, -1);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < NPROM; k++) largos[k] = $urandom_range(2, 60);
            runWindow("contrnd", 1, -1);
        end
        largos = '{37, 41, 29, 33};
        runWindow("contcut", 1, 2);
        finTiro("contcut", int'(valor_periodo));
        repeat (30) applyStimulus(1'b1, 1'b1);
        checkOutput("contcut.pulsos_despues", pulsos, expPulsos);
        checkOutput("contcut.ocupado_despues", int'(ocupado), 0);

        $display("[TB] continuous overflow rearms");
        armar("covf", 1'b1);
        overflow("covf");
        applyStimulus(1'b0, 1'b1);
        checkOutput("covf.ocupado_rearm", int'(ocupado), 1);
        checkOutput("covf.valido_rearm", int'(dato_valido), 0);
        applyStimulus(1'b1, 1'b1);
        largos = '{20, 20, 20, 20};
        runWindow("covf", 0, 3);
        finTiro("covf", 20);

        $display("[TB] asynchronous reset mid-window");
        armar("rst", 1'b1);
        largos = '{30, 30, 30, 30};
        runWindow("rst", 0, -1);
        repeat (70) applyStimulus(1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst.valor", int'(valor_periodo), 0);
        checkOutput("rst.valido", int'(dato_valido), 0);
        checkOutput("rst.desborde", int'(desborde), 0);
        checkOutput("rst.ocupado", int'(ocupado), 0);
        continuo = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(i % 5 == 0, 1'b1);
        checkOutput("rst.pulsos", pulsos, expPulsos);
        checkOutput("rst.ocupado_despues", int'(ocupado), 0);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
